io_stage: RTL and testbench
===========================

Name: io_stage

Overview:
- Memory-access (IO) stage of the 5-stage MIPS pipeline, between EX and WB.
- Holds the instruction issued by EX in a pipeline register and waits for load data from the data SRAM.
- Selects the final result (load data or ALU result) and forwards it to WB over the IOToWBData bus.
- Reports its pending destination register to ID over the IOToIDBackPassData bus for hazard detection.

Parameters:
- CPU_DATA_WIDTH, 32, datapath width; must match cpu_core_params::CPU_DATA_WIDTH.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ex_to_io_valid  input  1  EX presents a valid instruction.
- io_allow_in  output  1  IO can accept a new instruction this cycle.
- ex_to_io_bus  input  72  EXToIOData {valid, program_count, alu_result, destination_register, register_write, result_is_from_memory}.
- io_to_wb_valid  output  1  IO presents a completed instruction to WB.
- wb_allow_in  input  1  WB can accept an instruction this cycle.
- io_to_wb_bus  output  71  IOToWBData {valid, program_count, final_result, register_file_address, register_file_write_enabled}.
- io_to_id_back_pass  output  5  IOToIDBackPassData {write_register}.
- data_sram_rdata  input  32  load data returned by data SRAM.
- data_sram_rdata_valid  input  1  data_sram_rdata is valid this cycle.

Behaviour:
- State:
  - io_valid (1b).
  - Captured EX bus register (72b).
  - load_data_held flag (1b).
  - load_data_buffer (32b).
- Reset (synchronous, active-high): all of the above clear to 0. After reset, io_allow_in=1, io_to_wb_valid=0, io_to_id_back_pass=0 and io_to_wb_bus=0 until the first instruction is captured.
- Mid-operation reset: discards any in-flight instruction and any held data. No output to WB in the following cycle.
- io_is_load = captured result_is_from_memory.
- io_ready_go = !io_is_load || load_data_held || data_sram_rdata_valid.
- io_allow_in = !io_valid || (io_ready_go && wb_allow_in). Combinational.
- io_to_wb_valid = io_valid && io_ready_go. Combinational.
- Capture: when io_allow_in, io_valid <= ex_to_io_valid. The bus register loads only when ex_to_io_valid && io_allow_in; otherwise it holds its value.
- Latency:
  - Non-load: 1 cycle in IO with no stall from WB.
  - Load: completes in the cycle data_sram_rdata_valid is seen (earliest is the first IO cycle).
- Load buffering:
  - Condition: io_valid && io_is_load && !load_data_held && data_sram_rdata_valid && !wb_allow_in.
  - Action: load_data_buffer <= data_sram_rdata; load_data_held <= 1.
- Held-flag clear: load_data_held clears when the instruction leaves IO (io_to_wb_valid && wb_allow_in).
  - If a new instruction enters in that same cycle, the flag is 0 for it.
- final_result:
  - io_is_load && load_data_held: load_data_buffer.
  - io_is_load && !load_data_held: data_sram_rdata.
  - otherwise: alu_result.
- Ignored SRAM responses: data_sram_rdata_valid is ignored when !io_valid, when !io_is_load, or when load_data_held=1. Only one response per load is used.
- io_to_wb_bus fields:
  - valid = io_to_wb_valid.
  - program_count: passthrough.
  - register_file_address = destination_register.
  - register_file_write_enabled = io_valid && register_write.
- io_to_id_back_pass.write_register = (io_valid && register_write) ? destination_register : 0. This is also asserted while a load is stalled, so ID stalls consumers.
- Simultaneous events:
  - WB accepting and EX offering in the same cycle gives back-to-back throughput, 1 instruction/cycle.
  - An instruction with ex_to_io_valid=0 that is accepted empties the stage.
- No exceptions, flushes or byte/halfword load extraction in this block. Full-word loads only.

Test Plan:
- Reset held 2 cycles, then released -> io_allow_in=1, io_to_wb_valid=0, back_pass=0, bus=0.
- Non-load addu, pc=0xBFC00000, alu_result=0x12345678, dest=5, wb_allow_in=1 -> next cycle io_to_wb_valid=1, final_result=0x12345678, register_file_address=5, write_enabled=1, back_pass=5.
- lw, dest=8, rdata_valid delayed 3 cycles with rdata=0xDEADBEEF -> io_to_wb_valid=0 and io_allow_in=0 for 3 cycles with back_pass=8, then final_result=0xDEADBEEF for one cycle.
- lw, rdata=0xCAFEF00D valid for one cycle while wb_allow_in=0 for 4 cycles, rdata changed to 0x0 afterwards -> buffered, io_to_wb_valid held 1, final_result stays 0xCAFEF00D until accepted, load_data_held then 0.
- 4 back-to-back non-loads with wb_allow_in=1 -> 4 consecutive WB transfers, PCs in order. Toggling wb_allow_in=0 for 1 cycle stalls IO and deasserts io_allow_in that cycle with no loss or duplication.
- Spurious rdata_valid=1 with IO empty or holding sw (register_write=0) -> no effect, final_result=alu_result, write_enabled=0, back_pass=0.

Source files
------------

// File: rtl/io_stage.sv
// Memory-access (IO) stage: holds the instruction from EX, waits for load data,
// and forwards the final result to WB.

package io_stage_pkg;

  localparam int unsigned CPU_DATA_WIDTH = 32;
  localparam int unsigned REG_ADDR_W     = 5;

  typedef struct packed {
    logic                      valid;
    logic [CPU_DATA_WIDTH-1:0] program_count;
    logic [CPU_DATA_WIDTH-1:0] alu_result;
    logic [REG_ADDR_W-1:0]     destination_register;
    logic                      register_write;
    logic                      result_is_from_memory;
  } ex_to_io_t;

  typedef struct packed {
    logic                      valid;
    logic [CPU_DATA_WIDTH-1:0] program_count;
    logic [CPU_DATA_WIDTH-1:0] final_result;
    logic [REG_ADDR_W-1:0]     register_file_address;
    logic                      register_file_write_enabled;
  } io_to_wb_t;

endpackage

module io_stage
  import io_stage_pkg::*;
#(
  parameter int unsigned CPU_DATA_WIDTH = io_stage_pkg::CPU_DATA_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ex_to_io_valid,
  output logic                          io_allow_in,
  input  logic [2*CPU_DATA_WIDTH+8-1:0] ex_to_io_bus,
  output logic                          io_to_wb_valid,
  input  logic                          wb_allow_in,
  output logic [2*CPU_DATA_WIDTH+7-1:0] io_to_wb_bus,
  output logic [REG_ADDR_W-1:0]         io_to_id_back_pass,
  input  logic [CPU_DATA_WIDTH-1:0]     data_sram_rdata,
  input  logic                          data_sram_rdata_valid
);

  logic                      io_valid;
  ex_to_io_t                 ex_reg;
  logic                      load_data_held;
  logic [CPU_DATA_WIDTH-1:0] load_data_buffer;

  logic                      io_is_load;
  logic                      io_ready_go;
  logic                      io_leaving;
  logic                      buffer_load;
  logic [CPU_DATA_WIDTH-1:0] final_result;
  io_to_wb_t                 wb_payload;

  // The EX-side valid bit is redundant with ex_to_io_valid once captured.
  logic unused_ex_valid;
  assign unused_ex_valid = ex_reg.valid;

  // Handshake and result selection.
  always_comb begin
    io_is_load     = ex_reg.result_is_from_memory;
    io_ready_go    = !io_is_load || load_data_held || data_sram_rdata_valid;
    io_allow_in    = !io_valid || (io_ready_go && wb_allow_in);
    io_to_wb_valid = io_valid && io_ready_go;
    io_leaving     = io_to_wb_valid && wb_allow_in;
    // Park a load response that WB cannot take yet; the SRAM only returns it once.
    buffer_load    = io_valid && io_is_load && !load_data_held &&
                     data_sram_rdata_valid && !wb_allow_in;

    final_result = ex_reg.alu_result;
    if (io_is_load) begin
      final_result = load_data_held ? load_data_buffer : data_sram_rdata;
    end
  end

  // Outgoing WB payload and hazard back-pass to ID (held during load stalls).
  always_comb begin
    wb_payload                             = '0;
    wb_payload.valid                       = io_to_wb_valid;
    wb_payload.program_count               = ex_reg.program_count;
    wb_payload.final_result                = final_result;
    wb_payload.register_file_address       = ex_reg.destination_register;
    wb_payload.register_file_write_enabled = io_valid && ex_reg.register_write;

    io_to_wb_bus       = wb_payload;
    io_to_id_back_pass = (io_valid && ex_reg.register_write) ?
                         ex_reg.destination_register : REG_ADDR_W'(0);
  end

  // Pipeline register and load-data buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_valid         <= 1'b0;
      ex_reg           <= '0;
      load_data_held   <= 1'b0;
      load_data_buffer <= '0;
    end else begin
      if (io_allow_in) begin
        io_valid <= ex_to_io_valid;
      end
      if (ex_to_io_valid && io_allow_in) begin
        ex_reg <= ex_to_io_t'(ex_to_io_bus);
      end
      if (io_leaving) begin
        load_data_held <= 1'b0;
      end else if (buffer_load) begin
        load_data_held   <= 1'b1;
        load_data_buffer <= data_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_io_stage.sv
// Directed bench for io_stage: cycle table plus a mid-operation reset sequence.

module tb_io_stage;

  logic        clock;
  logic        reset;
  logic        ex_to_io_valid;
  logic        io_allow_in;
  logic [71:0] ex_to_io_bus;
  logic        io_to_wb_valid;
  logic        wb_allow_in;
  logic [70:0] io_to_wb_bus;
  logic [4:0]  io_to_id_back_pass;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rdata_valid;

  int n_checks = 0;
  int n_fail   = 0;

  io_stage dut (
    .clock                 (clock),
    .reset                 (reset),
    .ex_to_io_valid        (ex_to_io_valid),
    .io_allow_in           (io_allow_in),
    .ex_to_io_bus          (ex_to_io_bus),
    .io_to_wb_valid        (io_to_wb_valid),
    .wb_allow_in           (wb_allow_in),
    .io_to_wb_bus          (io_to_wb_bus),
    .io_to_id_back_pass    (io_to_id_back_pass),
    .data_sram_rdata       (data_sram_rdata),
    .data_sram_rdata_valid (data_sram_rdata_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ev;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic        rw;
    logic        ld;
    logic        wa;
    logic        rv;
    logic [31:0] rd;
    logic        xa;
    logic        xv;
    logic [4:0]  xbp;
    logic        cd;
    logic [31:0] xfr;
    logic [4:0]  xra;
    logic        xwe;
    logic [31:0] xpc;
  } vec_t;

  localparam int unsigned N_VEC = 24;
  vec_t tbl [N_VEC];

  function automatic vec_t mk(
    input logic ev, input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] dst,
    input logic rw, input logic ld, input logic wa, input logic rv, input logic [31:0] rd,
    input logic xa, input logic xv, input logic [4:0] xbp,
    input logic cd, input logic [31:0] xfr, input logic [4:0] xra, input logic xwe,
    input logic [31:0] xpc);
    vec_t v;
    v.ev = ev; v.pc = pc; v.alu = alu; v.dst = dst; v.rw = rw; v.ld = ld;
    v.wa = wa; v.rv = rv; v.rd = rd;
    v.xa = xa; v.xv = xv; v.xbp = xbp;
    v.cd = cd; v.xfr = xfr; v.xra = xra; v.xwe = xwe; v.xpc = xpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [4:0] dst, input logic rw, input logic ld,
                       input logic wa, input logic rv, input logic [31:0] rd);
    ex_to_io_valid        = ev;
    ex_to_io_bus          = {ev, pc, alu, dst, rw, ld};
    wb_allow_in           = wa;
    data_sram_rdata_valid = rv;
    data_sram_rdata       = rd;
  endtask

  // Inputs are applied just after a rising edge and outputs sampled on the falling edge.
  task automatic check_outputs(input string tag, input logic xa, input logic xv,
                               input logic [4:0] xbp, input logic cd,
                               input logic [31:0] xfr, input logic [4:0] xra,
                               input logic xwe, input logic [31:0] xpc);
    logic [70:0] bus;
    @(negedge clock);
    bus = io_to_wb_bus;
    chk({tag, ".allow_in"},  71'(io_allow_in), 71'(xa));
    chk({tag, ".wb_valid"},  71'(io_to_wb_valid), 71'(xv));
    chk({tag, ".bus_valid"}, 71'(bus[70]), 71'(xv));
    chk({tag, ".back_pass"}, 71'(io_to_id_back_pass), 71'(xbp));
    if (cd) begin
      chk({tag, ".final"}, 71'(bus[37:6]), 71'(xfr));
      chk({tag, ".rf_addr"}, 71'(bus[5:1]), 71'(xra));
      chk({tag, ".rf_we"}, 71'(bus[0]), 71'(xwe));
      chk({tag, ".pc"}, 71'(bus[69:38]), 71'(xpc));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // ev, pc, alu, dst, rw, ld, wa, rv, rd, xa, xv, xbp, cd, xfr, xra, xwe, xpc
    // non-load addu
    tbl[0]  = mk(1, 32'hBFC00000, 32'h12345678, 5, 1, 0, 1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                          1, 1, 5,  1, 32'h12345678, 5, 1, 32'hBFC00000);
    // lw with data 3 cycles late
    tbl[2]  = mk(1, 32'hBFC00004, 32'h100, 8, 1, 1, 1, 0, 0,         1, 0, 0,  0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                          0, 0, 8,  1, 0, 8, 1, 32'hBFC00004);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                          0, 0, 8,  1, 0, 8, 1, 32'hBFC00004);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                          0, 0, 8,  1, 0, 8, 1, 32'hBFC00004);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF,               1, 1, 8,  1, 32'hDEADBEEF, 8, 1, 32'hBFC00004);
    // lw whose data arrives while WB stalls; later SRAM traffic must be ignored
    tbl[7]  = mk(1, 32'hBFC00008, 32'h200, 9, 1, 1, 0, 0, 0,         1, 0, 0,  0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D,               0, 1, 9,  1, 32'hCAFEF00D, 9, 1, 32'hBFC00008);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 1, 9,  1, 32'hCAFEF00D, 9, 1, 32'hBFC00008);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                          0, 1, 9,  1, 32'hCAFEF00D, 9, 1, 32'hBFC00008);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111,               0, 1, 9,  1, 32'hCAFEF00D, 9, 1, 32'hBFC00008);
    // accept buffered load while next lw enters; next lw must wait for its own data
    tbl[12] = mk(1, 32'hBFC0000C, 32'h300, 10, 1, 1, 1, 0, 0,        1, 1, 9,  1, 32'hCAFEF00D, 9, 1, 32'hBFC00008);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                          0, 0, 10, 1, 0, 10, 1, 32'hBFC0000C);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h0BADF00D,               1, 1, 10, 1, 32'h0BADF00D, 10, 1, 32'hBFC0000C);
    // back-to-back non-loads with one WB stall cycle
    tbl[15] = mk(1, 32'hBFC00010, 32'hA0A0A0A0, 11, 1, 0, 1, 0, 0,   1, 0, 0,  0, 0, 0, 0, 0);
    tbl[16] = mk(1, 32'hBFC00014, 32'hA1A1A1A1, 12, 1, 0, 1, 0, 0,   1, 1, 11, 1, 32'hA0A0A0A0, 11, 1, 32'hBFC00010);
    tbl[17] = mk(1, 32'hBFC00018, 32'hA2A2A2A2, 13, 1, 0, 0, 0, 0,   0, 1, 12, 1, 32'hA1A1A1A1, 12, 1, 32'hBFC00014);
    tbl[18] = mk(1, 32'hBFC00018, 32'hA2A2A2A2, 13, 1, 0, 1, 0, 0,   1, 1, 12, 1, 32'hA1A1A1A1, 12, 1, 32'hBFC00014);
    tbl[19] = mk(1, 32'hBFC0001C, 32'hA3A3A3A3, 14, 1, 0, 1, 0, 0,   1, 1, 13, 1, 32'hA2A2A2A2, 13, 1, 32'hBFC00018);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,                          1, 1, 14, 1, 32'hA3A3A3A3, 14, 1, 32'hBFC0001C);
    // spurious SRAM responses: empty stage, then sw
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF,               1, 0, 0,  1, 32'hA3A3A3A3, 14, 0, 32'hBFC0001C);
    tbl[22] = mk(1, 32'hBFC00020, 32'h400, 7, 0, 0, 1, 0, 0,         1, 0, 0,  0, 0, 0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF,               1, 1, 0,  1, 32'h400, 7, 0, 32'hBFC00020);

    // Reset for two cycles.
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset.allow_in",  71'(io_allow_in), 71'(1));
    chk("reset.wb_valid",  71'(io_to_wb_valid), 71'(0));
    chk("reset.back_pass", 71'(io_to_id_back_pass), 71'(0));
    chk("reset.bus",       io_to_wb_bus, 71'(0));
    @(posedge clock);
    #1;

    for (int i = 0; i < int'(N_VEC); i++) begin
      drive(tbl[i].ev, tbl[i].pc, tbl[i].alu, tbl[i].dst, tbl[i].rw, tbl[i].ld,
            tbl[i].wa, tbl[i].rv, tbl[i].rd);
      check_outputs($sformatf("vec%0d", i), tbl[i].xa, tbl[i].xv, tbl[i].xbp,
                    tbl[i].cd, tbl[i].xfr, tbl[i].xra, tbl[i].xwe, tbl[i].xpc);
    end

    // Mid-operation reset with a buffered load in flight.
    drive(1, 32'hBFC00030, 32'h500, 3, 1, 1, 0, 0, 0);
    check_outputs("mr0", 1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h12121212);
    check_outputs("mr1", 0, 1, 3, 1, 32'h12121212, 3, 1, 32'hBFC00030);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(1, 32'hBFC00034, 32'h600, 4, 1, 1, 1, 0, 0);
    @(negedge clock);
    chk("mr2.bus", io_to_wb_bus, 71'(0));
    chk("mr2.allow_in", 71'(io_allow_in), 71'(1));
    chk("mr2.wb_valid", 71'(io_to_wb_valid), 71'(0));
    chk("mr2.back_pass", 71'(io_to_id_back_pass), 71'(0));
    @(posedge clock);
    #1;
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check_outputs("mr3", 0, 0, 4, 1, 0, 4, 1, 32'hBFC00034);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h77777777);
    check_outputs("mr4", 1, 1, 4, 1, 32'h77777777, 4, 1, 32'hBFC00034);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
